// File: rtl/mem_lsu_ctrl.sv
// Single-outstanding load/store controller driving Mem4K port B for one cycle per access.
// Accept->rsp_valid latency: load 3, store 2, error 1; req_ready only in IDLE, response held until rsp_ready.
module mem_lsu_ctrl #(
  parameter int MEM_BYTES   = 4096,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        B_EnWR,
  output logic [1:0]  B_Size,
  output logic [31:0] B_ABus,
  output logic [31:0] B_DBusW,
  input  logic [31:0] B_DBusR
);
  localparam logic [1:0] MW_BYTE = 2'd0;
  localparam logic [1:0] MW_HALF = 2'd1;
  localparam logic [1:0] MW_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q, uns_q;
  logic [2:0]  nbytes;
  logic        bad_size, misaligned, out_of_range, req_err;
  logic [32:0] end_addr;
  logic [31:0] load_ext;

  // 33-bit end address so an address near 2^32 cannot wrap into range.
  always_comb begin
    nbytes   = 3'd4;
    bad_size = 1'b0;
    case (req_size)
      MW_BYTE: nbytes = 3'd1;
      MW_HALF: nbytes = 3'd2;
      MW_WORD: nbytes = 3'd4;
      default: bad_size = 1'b1;
    endcase
    misaligned   = CHECK_ALIGN && ((req_size == MW_HALF && req_addr[0]) ||
                                   (req_size == MW_WORD && req_addr[1:0] != 2'b00));
    end_addr     = {1'b0, req_addr} + {30'd0, nbytes};
    out_of_range = end_addr > 33'(MEM_BYTES);
    req_err      = bad_size | misaligned | out_of_range;
  end

  // Mem4K leaves upper lanes stale on narrow reads, so only the addressed lanes are used.
  always_comb begin
    case (B_Size)
      MW_BYTE: load_ext = {{24{~uns_q & B_DBusR[7]}}, B_DBusR[7:0]};
      MW_HALF: load_ext = {{16{~uns_q & B_DBusR[15]}}, B_DBusR[15:0]};
      default: load_ext = B_DBusR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_err ? RESP : ISSUE;
      end
      ISSUE:   state_nxt = we_q ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      B_Size    <= MW_WORD;
      B_ABus    <= 32'd0;
      B_DBusW   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            B_Size    <= req_size;
            B_ABus    <= req_addr;
            B_DBusW   <= req_wdata;
            rsp_err   <= req_err;
            rsp_rdata <= 32'd0;
          end
        end
        WAIT:    rsp_rdata <= load_ext;
        default: ;
      endcase
    end
  end

  // Gated by rst_n directly so a reset landing mid-ISSUE cannot commit the store.
  assign B_EnWR = rst_n & (state == ISSUE) & we_q;

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Bench for mem_lsu_ctrl: Mem4K-like port B model, transaction-level reference model with
// a per-cycle compare process, plus directed vectors with literal expected values.
module tb_mem_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        B_EnWR;
  logic [1:0]  B_Size;
  logic [31:0] B_ABus, B_DBusW, B_DBusR;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_lsu_ctrl #(.MEM_BYTES(4096), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .B_EnWR(B_EnWR), .B_Size(B_Size), .B_ABus(B_ABus), .B_DBusW(B_DBusW), .B_DBusR(B_DBusR)
  );

  // Mem4K port B: little-endian, registered read, narrow reads leave stale upper lanes.
  bit [7:0] mem [4096];
  always @(posedge clk) begin
    if (B_EnWR) begin
      mem[B_ABus[11:0]] <= B_DBusW[7:0];
      if (B_Size != 2'd0) mem[B_ABus[11:0] + 12'd1] <= B_DBusW[15:8];
      if (B_Size != 2'd0 && B_Size != 2'd1) begin
        mem[B_ABus[11:0] + 12'd2] <= B_DBusW[23:16];
        mem[B_ABus[11:0] + 12'd3] <= B_DBusW[31:24];
      end
    end
    case (B_Size)
      2'd0:    B_DBusR <= {24'hA5A5A5, mem[B_ABus[11:0]]};
      2'd1:    B_DBusR <= {16'h5A5A, mem[B_ABus[11:0] + 12'd1], mem[B_ABus[11:0]]};
      default: B_DBusR <= {mem[B_ABus[11:0] + 12'd3], mem[B_ABus[11:0] + 12'd2],
                           mem[B_ABus[11:0] + 12'd1], mem[B_ABus[11:0]]};
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at t=%0t", name, $time);
  endtask

  // Reference model: architectural byte memory, updated when a store's response is taken.
  bit [7:0] ref_mem [4096];

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, output logic [31:0] rd,
                                output logic err, output int lat);
    int     nb;
    longint v;
    nb  = size_bytes(sz);
    err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
          (longint'({32'd0, a}) + nb > 4096);
    rd  = 32'd0;
    if (err) lat = 1;
    else if (we) lat = 2;
    else begin
      lat = 3;
      v = 0;
      for (int k = nb - 1; k >= 0; k--) v = v * 256 + ref_mem[int'(a[11:0]) + k];
      if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      rd = v[31:0];
    end
  endfunction

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          due;
  } txn_t;

  txn_t        q[$];
  int          acc_log[$];
  logic [31:0] rsp_log[$];
  int          cyc = 0;
  int          enwr_cnt = 0;

  // Compare process: at each falling edge the model says what every handshake output must be.
  always @(negedge clk) begin
    txn_t t;
    logic idle_m, exp_v, exp_en;
    int   lat;
    cyc++;
    if (B_EnWR) enwr_cnt++;
    if (!rst_n) begin
      chk1("B_EnWR_in_reset", B_EnWR, 1'b0);
      q.delete();
    end else begin
      idle_m = (q.size() == 0);
      exp_v  = 1'b0;
      exp_en = 1'b0;
      if (!idle_m) begin
        exp_v  = (cyc >= q[0].due);
        exp_en = q[0].we && !q[0].err && (cyc == q[0].acc + 1);
      end
      chk1("req_ready", req_ready, idle_m);
      chk1("rsp_valid", rsp_valid, exp_v);
      chk1("B_EnWR", B_EnWR, exp_en);
      if (exp_v) begin
        chk("rsp_rdata", rsp_rdata, q[0].rdata);
        chk1("rsp_err", rsp_err, q[0].err);
        if (rsp_ready) begin
          if (q[0].we && !q[0].err)
            for (int k = 0; k < size_bytes(q[0].sz); k++)
              ref_mem[int'(q[0].addr[11:0]) + k] = 8'(q[0].wdata >> (8 * k));
          rsp_log.push_back(rsp_rdata);
          void'(q.pop_front());
        end
      end
      if (idle_m && req_valid) begin
        model(req_we, req_size, req_unsigned, req_addr, t.rdata, t.err, lat);
        t.we    = req_we;
        t.sz    = req_size;
        t.addr  = req_addr;
        t.wdata = req_wdata;
        t.acc   = cyc;
        t.due   = cyc + lat;
        q.push_back(t);
        acc_log.push_back(cyc);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) tmo("req_ready");
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) tmo("rsp_valid");
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
  endtask

  // One complete transaction with rsp_ready high; returns data, error flag and latency.
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    drive(we, sz, uns, a, wd);
    req_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  logic [31:0] t6_addr [4] = '{32'h10, 32'h20, 32'h40, 32'hFFC};
  logic [31:0] t6_data [4] = '{32'hDEADBEEF, 32'h000080F0, 32'hCAFEF00D, 32'hAB000000};

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, e0, base_a, base_r, n;

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_B_ABus", B_ABus, 32'h0);
    chk("rst_B_DBusW", B_DBusW, 32'h0);
    chk("rst_B_Size", {30'd0, B_Size}, 32'd2);
    rst_n = 1'b1;

    // Store word then load it back.
    e0 = enwr_cnt;
    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("st_lat", lat, 2); chk1("st_err", er, 1'b0); chk("st_rdata", rd, 32'h0);
    chk("st_enwr_cycles", enwr_cnt - e0, 1);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("ldw_lat", lat, 3); chk1("ldw_err", er, 1'b0); chk("ldw_rdata", rd, 32'hDEADBEEF);

    // Extension of narrow loads.
    txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h000080F0, rd, er, lat);
    txn(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, rd, er, lat); chk("ldb_s", rd, 32'hFFFFFFF0);
    txn(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, rd, er, lat); chk("ldb_u", rd, 32'h000000F0);
    txn(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, rd, er, lat); chk("ldh_s", rd, 32'hFFFF80F0);
    txn(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, rd, er, lat); chk("ldh_u", rd, 32'h000080F0);
    txn(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, rd, er, lat); chk("ldb_s_21", rd, 32'hFFFFFF80);

    // Error and range boundaries.
    e0 = enwr_cnt;
    txn(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, rd, er, lat);
    chk("mis_lat", lat, 1); chk1("mis_err", er, 1'b1); chk("mis_rdata", rd, 32'h0);
    txn(1'b1, 2'd2, 1'b0, 32'h2, 32'h12345678, rd, er, lat); chk1("mis_st_err", er, 1'b1);
    chk("err_no_enwr", enwr_cnt - e0, 0);
    txn(1'b1, 2'd0, 1'b0, 32'hFFF, 32'h000000AB, rd, er, lat);
    chk1("stb_fff_err", er, 1'b0); chk("stb_fff_lat", lat, 2);
    txn(1'b0, 2'd0, 1'b1, 32'hFFF, 32'h0, rd, er, lat); chk("ldb_fff", rd, 32'h000000AB);
    txn(1'b0, 2'd2, 1'b0, 32'hFFD, 32'h0, rd, er, lat); chk1("ldw_ffd_err", er, 1'b1);
    txn(1'b0, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h0, rd, er, lat); chk1("wrap_err", er, 1'b1);
    txn(1'b0, 2'd0, 1'b0, 32'h1000, 32'h0, rd, er, lat); chk1("ldb_1000_err", er, 1'b1);
    txn(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, rd, er, lat);
    chk1("badsize_err", er, 1'b1); chk("badsize_lat", lat, 1);

    // Response backpressure with a second request waiting.
    rsp_ready = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    req_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    req_addr = 32'h20;
    wait_rsp(lat);
    chk("hold_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("hold_valid", rsp_valid, 1'b1);
      chk("hold_rdata", rsp_rdata, 32'hDEADBEEF);
      chk1("hold_req_ready", req_ready, 1'b0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    chk("second_rdata", rsp_rdata, 32'h000080F0);
    @(posedge clk); #1;

    // Reset landing mid-ISSUE of a store.
    txn(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, rd, er, lat);
    drive(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344);
    req_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk1("abort_enwr", B_EnWR, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("abort_req_ready", req_ready, 1'b1);
    chk1("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_B_ABus", B_ABus, 32'h0);
    chk("abort_mem40", {mem[12'h43], mem[12'h42], mem[12'h41], mem[12'h40]}, 32'hCAFEF00D);
    @(posedge clk); #1;
    txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er, lat); chk("abort_ld40", rd, 32'hCAFEF00D);

    // Back-to-back loads with req_valid and rsp_ready held high.
    base_a = acc_log.size();
    base_r = rsp_log.size();
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd2, 1'b0, t6_addr[i], 32'h0);
      wait_ready();
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || acc_log.size() < base_a + 4 || rsp_log.size() < base_r + 4)
      tmo("b2b_drain");
    else begin
      for (int i = 1; i < 4; i++) chk("b2b_interval", acc_log[base_a + i] - acc_log[base_a + i - 1], 4);
      for (int i = 0; i < 4; i++) chk("b2b_data", rsp_log[base_r + i], t6_data[i]);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
